branch_predict_unit: RTL
========================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and PC width.
REQ-002 Parameter BHT_ENTRIES, default 64: branch history table depth; SHALL be a power of two, 4..1024.
REQ-003 Parameter INDEX_BITS, default $clog2(BHT_ENTRIES): table index width (derived, not overridden).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  decode stall (load-use bubble); suppresses table update and statistics.
REQ-008 lookup_pc  in  XLEN  PC of the instruction in fetch.
REQ-009 lookup_imm  in  XLEN  sign-extended B-immediate of the fetched instruction.
REQ-010 lookup_is_branch  in  1  fetched instruction is B-type.
REQ-011 predict_taken  out  1  prediction for lookup_pc.
REQ-012 predict_target  out  XLEN  lookup_pc + lookup_imm, modulo 2^XLEN.
REQ-013 resolve_valid  in  1  B-type instruction present in decode.
REQ-014 resolve_pc  in  XLEN  PC of the decode instruction.
REQ-015 branch_type  in  3  funct3: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
REQ-016 left_operand, right_operand  in  XLEN each  forwarded rs1 and rs2 values.
REQ-017 resolve_target  in  XLEN  computed branch target.
REQ-018 resolve_predicted  in  1  prediction made for this instruction in fetch.
REQ-019 actual_taken  out  1  resolved outcome.
REQ-020 mispredict  out  1  resolved outcome differs from prediction; drives IF_Flush.
REQ-021 redirect_pc  out  XLEN  correct next PC on mispredict, else 0.
REQ-022 illegal_branch  out  1  resolve_valid with funct3 010 or 011.

Function
REQ-023 Table: BHT_ENTRIES 2-bit saturating counters with states SNT=00, WNT=01, WT=10, ST=11; index = pc[INDEX_BITS+1:2].
REQ-024 predict_taken SHALL be combinational: counter[idx(lookup_pc)][1] AND lookup_is_branch.
REQ-025 Comparisons SHALL be combinational from the operands: BLT/BGE two's-complement signed; BLTU/BGEU unsigned (left<right, left>=right); BEQ/BNE equality.
REQ-026 actual_taken = compare result when resolve_valid and funct3 legal, else 0.
REQ-027 mispredict = resolve_valid AND NOT stall AND legal funct3 AND (actual_taken != resolve_predicted).
REQ-028 redirect_pc = resolve_target if actual_taken, else resolve_pc+4; 0 when mispredict=0.
REQ-029 Update: on a rising edge with resolve_valid, NOT stall, legal funct3, counter[idx(resolve_pc)] SHALL increment if taken (saturate at ST), else decrement (saturate at SNT); one-cycle latency.
REQ-030 Same-cycle lookup and update at the same index: lookup SHALL return the pre-update value (no bypass).
REQ-031 Illegal funct3: illegal_branch=1, actual_taken=0, mispredict=0, no table update.
REQ-032 Stall high: outputs still evaluate, but mispredict is forced 0 and no table or statistics update occurs.

Reset
REQ-033 rst=1 at a rising edge SHALL set all counters to WNT in that single cycle and clear statistics.
REQ-034 During rst, mispredict=0, redirect_pc=0 and predict_taken=0; an update coincident with rst SHALL be discarded.

Configuration
REQ-035 Macro BRANCH_STATS_EN: when defined, add outputs stat_branches and stat_mispredicts (32 bits each, wrapping at 2^32), incremented on each updating resolve and each mispredict; when undefined, these ports and their counters SHALL not exist.

Verification
REQ-036 Reset, then lookup_pc=0x100 branch -> predict_taken=0 (WNT).
REQ-037 Resolve pc 0x100 BEQ 5,5 taken twice -> counter ST; lookup 0x100 predict_taken=1; resolve BNE 5,5 pred=1 -> mispredict=1, redirect_pc=0x104.
REQ-038 BLT 0xFFFFFFFF vs 1 -> taken; BLTU same operands -> not taken; BGE 0x80000000 vs 0x80000000 -> taken.
REQ-039 stall=1 with mispredicting resolve -> mispredict=0; counter unchanged on the following lookup.
REQ-040 Same-cycle lookup and update at index 3 -> lookup returns old state; the next cycle returns the updated state.
REQ-041 funct3=010 -> illegal_branch=1, no update; with BRANCH_STATS_EN, stat_branches unchanged.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor (2-bit saturating counters) plus decode-stage branch resolution.
// Optional statistics outputs are enabled by defining BRANCH_STATS_EN.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    localparam int INDEX_BITS = $clog2(BHT_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [XLEN-1:0] lookup_pc,
    input  logic [XLEN-1:0] lookup_imm,
    input  logic            lookup_is_branch,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic [2:0]      branch_type,
    input  logic [XLEN-1:0] left_operand,
    input  logic [XLEN-1:0] right_operand,
    input  logic [XLEN-1:0] resolve_target,
    input  logic            resolve_predicted,
    output logic            actual_taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal_branch
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] ST  = 2'b11;

    logic [1:0]            cnt_vec [BHT_ENTRIES];
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] resolve_idx;
    logic                  funct3_legal;
    logic                  cmp_result;
    logic                  update_en;

    assign lookup_idx  = lookup_pc[INDEX_BITS+1:2];
    assign resolve_idx = resolve_pc[INDEX_BITS+1:2];

    always_comb begin
        cmp_result   = 1'b0;
        funct3_legal = 1'b1;
        case (branch_type)
            3'b000:  cmp_result = (left_operand == right_operand);
            3'b001:  cmp_result = (left_operand != right_operand);
            3'b100:  cmp_result = ($signed(left_operand) <  $signed(right_operand));
            3'b101:  cmp_result = ($signed(left_operand) >= $signed(right_operand));
            3'b110:  cmp_result = (left_operand <  right_operand);
            3'b111:  cmp_result = (left_operand >= right_operand);
            default: funct3_legal = 1'b0;
        endcase
    end

    assign illegal_branch = resolve_valid && !funct3_legal;
    assign actual_taken   = resolve_valid && funct3_legal && cmp_result;
    assign mispredict     = resolve_valid && !stall && funct3_legal && !rst
                            && (actual_taken != resolve_predicted);
    assign redirect_pc    = !mispredict   ? '0 :
                            actual_taken  ? resolve_target :
                                            resolve_pc + XLEN'(4);
    assign update_en      = resolve_valid && !stall && funct3_legal;

    // Lookup reads the registered counter directly, so a same-cycle update is not visible.
    assign predict_taken  = cnt_vec[lookup_idx][1] && lookup_is_branch && !rst;
    assign predict_target = lookup_pc + lookup_imm;

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] state_reg;
            logic [1:0] state_next;
            always_comb begin
                state_next = state_reg;
                if (actual_taken) begin
                    if (state_reg != ST) state_next = state_reg + 2'd1;
                end else begin
                    if (state_reg != SNT) state_next = state_reg - 2'd1;
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= WNT;
                end else if (update_en && (resolve_idx == INDEX_BITS'(gi))) begin
                    state_reg <= state_next;
                end
            end
            assign cnt_vec[gi] = state_reg;
        end
    endgenerate

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            if (update_en)  stat_branches_reg    <= stat_branches_reg + 32'd1;
            if (mispredict) stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
        end
    end
    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule
